// File: rtl/alu_seq_flags_pkg.sv
// Shared encodings for the sequential flag-keeping ALU: opcodes, condition codes,
// shift types, FSM state, and the condition-pass evaluation against stored NZCV.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_ORR = 4'd4;
  localparam logic [3:0] OP_EOR = 4'd5;
  localparam logic [3:0] OP_CMP = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_MVN = 4'd8;
  localparam logic [3:0] OP_ADC = 4'd9;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [2:0] SH_NONE = 3'b000;
  localparam logic [2:0] SH_LSR  = 3'b001;
  localparam logic [2:0] SH_LSL  = 3'b010;
  localparam logic [2:0] SH_ROR  = 3'b011;
  localparam logic [2:0] SH_ASR  = 3'b100;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  function automatic logic cond_pass(input logic [3:0] cond,
                                     input logic n, input logic z,
                                     input logic c, input logic v);
    logic pass;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/alu_seq_flags_if.sv
// Request/response bundle between the register-read stage, the ALU and writeback.
interface alu_seq_flags_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [31:0]      inf;
  logic             out_valid;
  logic             executed;
  logic [WIDTH-1:0] r;
  logic             n;
  logic             z;
  logic             c;
  logic             v;

  modport master (
    output in_valid, a, b, inf,
    input  in_ready, out_valid, executed, r, n, z, c, v
  );

  modport slave (
    input  in_valid, a, b, inf,
    output in_ready, out_valid, executed, r, n, z, c, v
  );
endinterface

// File: rtl/alu_seq_flags_mul_iter.sv
// Iterative shift-add multiplier keeping the low WIDTH bits of the product.
// o_last flags the final iteration edge; o_result is the product that edge completes.
module alu_mul_iter #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_result
);

  localparam int ITERS = WIDTH / MUL_BITS;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] w_partial;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_partial = '0;
    for (int k = 0; k < MUL_BITS; k++) begin
      if (r_mplier[k]) w_partial = w_partial + (r_mcand << k);
    end
  end

  assign o_result = r_acc + w_partial;
  assign o_last   = r_busy && (r_cnt == LAST_CNT);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= o_result;
      r_mcand  <= r_mcand << MUL_BITS;
      r_mplier <= r_mplier >> MUL_BITS;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (o_last) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_flags.sv
// Handshaked ARM-style data-processing ALU with an architectural NZCV register.
// Single-cycle ops commit at the accept edge; MUL runs through alu_mul_iter.
module alu_seq_flags
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic          clk,
  input  logic          rst,
  alu_seq_flags_if.slave bus
);

  localparam int SH_W = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_next;
  logic             w_in_ready;

  logic [WIDTH-1:0] r_r;
  logic             r_n, r_z, r_c, r_v;
  logic             r_out_valid;
  logic             r_executed;
  logic             r_mul_s;

  logic [3:0]       w_cond;
  logic [3:0]       w_op;
  logic             w_s;
  logic [SH_W-1:0]  w_shamt;
  logic [2:0]       w_shtype;
  logic             w_unused_inf;

  logic             w_accept;
  logic             w_pass;
  logic             w_mul_start;
  logic             w_mul_last;
  logic [WIDTH-1:0] w_mul_result;

  logic [WIDTH:0]   w_ext_l;
  logic [WIDTH:0]   w_ext_r;
  logic [WIDTH:0]   w_ext_a;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_op1;
  logic             w_sc;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_arith_v;
  logic [WIDTH-1:0] w_res;
  logic             w_res_c;
  logic             w_res_v;

  assign w_cond       = bus.inf[31:28];
  assign w_op         = bus.inf[27:24];
  assign w_s          = bus.inf[23];
  assign w_shamt      = bus.inf[6 +: SH_W];
  assign w_shtype     = bus.inf[2:0];
  assign w_unused_inf = ^{bus.inf[22:6+SH_W], bus.inf[5:3]};

  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_pass      = cond_pass(w_cond, r_n, r_z, r_c, r_v);
  assign w_mul_start = w_accept && w_pass && (w_op == OP_MUL);

  // Extended shifts expose the last bit shifted out alongside the result.
  assign w_ext_l = {1'b0, bus.a} << w_shamt;
  assign w_ext_r = {bus.a, 1'b0} >> w_shamt;
  assign w_ext_a = $signed({bus.a, 1'b0}) >>> w_shamt;
  assign w_ror   = (bus.a >> w_shamt) | (bus.a << (WIDTH - int'(w_shamt)));

  always_comb begin
    w_op1 = bus.a;
    w_sc  = r_c;
    if (w_shamt != '0) begin
      case (w_shtype)
        SH_LSL: begin w_op1 = w_ext_l[WIDTH-1:0]; w_sc = w_ext_l[WIDTH]; end
        SH_LSR: begin w_op1 = w_ext_r[WIDTH:1];   w_sc = w_ext_r[0];     end
        SH_ASR: begin w_op1 = w_ext_a[WIDTH:1];   w_sc = w_ext_a[0];     end
        SH_ROR: begin w_op1 = w_ror;              w_sc = w_ror[WIDTH-1]; end
        default: ;
      endcase
    end
  end

  // One adder serves ADD/ADC and, via inverted b plus carry-in, SUB/CMP.
  always_comb begin
    w_b_eff = bus.b;
    w_cin   = 1'b0;
    case (w_op)
      OP_SUB, OP_CMP: begin w_b_eff = ~bus.b; w_cin = 1'b1; end
      OP_ADC:         w_cin = r_c;
      default: ;
    endcase
  end

  assign w_sum     = {1'b0, w_op1} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
  assign w_arith_v = (w_op1[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != w_op1[WIDTH-1]);

  always_comb begin
    w_res   = '0;
    w_res_c = r_c;
    w_res_v = r_v;
    case (w_op)
      OP_ADD, OP_SUB, OP_CMP, OP_ADC: begin
        w_res   = w_sum[WIDTH-1:0];
        w_res_c = w_sum[WIDTH];
        w_res_v = w_arith_v;
      end
      OP_AND: begin w_res = w_op1 & bus.b; w_res_c = w_sc; end
      OP_ORR: begin w_res = w_op1 | bus.b; w_res_c = w_sc; end
      OP_EOR: begin w_res = w_op1 ^ bus.b; w_res_c = w_sc; end
      OP_MOV: begin w_res = w_op1;         w_res_c = w_sc; end
      OP_MVN: begin w_res = ~w_op1;        w_res_c = w_sc; end
      default: ;
    endcase
  end

  alu_mul_iter #(
    .WIDTH    (WIDTH),
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_mul_start),
    .i_a      (w_op1),
    .i_b      (bus.b),
    .o_last   (w_mul_last),
    .o_result (w_mul_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_mul_start) w_state_next = MUL;
      MUL:     if (w_mul_last)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready = (r_state == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r         <= '0;
      r_n         <= 1'b0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_out_valid <= 1'b0;
      r_executed  <= 1'b0;
      r_mul_s     <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_executed  <= 1'b0;
      if (w_accept) begin
        if (!w_pass || (w_op > OP_ADC)) begin
          r_out_valid <= 1'b1;
        end else if (w_op == OP_MUL) begin
          r_mul_s <= w_s;
        end else begin
          r_out_valid <= 1'b1;
          r_executed  <= 1'b1;
          if (w_op != OP_CMP) r_r <= w_res;
          if (w_s || (w_op == OP_CMP)) begin
            r_n <= w_res[WIDTH-1];
            r_z <= (w_res == '0);
            r_c <= w_res_c;
            r_v <= w_res_v;
          end
        end
      end else if (w_mul_last) begin
        r_out_valid <= 1'b1;
        r_executed  <= 1'b1;
        r_r         <= w_mul_result;
        if (r_mul_s) begin
          r_n <= w_mul_result[WIDTH-1];
          r_z <= (w_mul_result == '0);
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.executed  = r_executed;
  assign bus.r         = r_r;
  assign bus.n         = r_n;
  assign bus.z         = r_z;
  assign bus.c         = r_c;
  assign bus.v         = r_v;

endmodule
